// File: rtl/usb_pkg.sv
// Shared ULPI register-port widths, arbiter state encoding and the latched
// downstream command payload.
package usb_pkg;

  localparam int unsigned ULPI_REG_ADDR_W = 8;
  localparam int unsigned ULPI_REG_DATA_W = 8;
  localparam int unsigned ARB_ID_W        = 3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DONE  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                       we;
    logic [ULPI_REG_ADDR_W-1:0] addr;
    logic [ULPI_REG_DATA_W-1:0] din;
  } ulpi_reg_cmd_t;

endpackage

// File: rtl/usb_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from
// last_i+1 with wrap-around.
module usb_rr_picker
  import usb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ARB_ID_W-1:0] last_i,
  output logic                valid_c,
  output logic [ARB_ID_W-1:0] idx_c
);

  // Scan from the farthest offset down so the nearest hit is assigned last.
  always_comb begin
    int unsigned        cand;
    logic [NUM_REQ-1:0] sh;
    valid_c = 1'b0;
    idx_c   = '0;
    cand    = 0;
    sh      = '0;
    for (int unsigned off = NUM_REQ; off >= 1; off--) begin
      cand = (32'(last_i) + off) % NUM_REQ;
      sh   = req_i >> cand;
      if (sh[0]) begin
        valid_c = 1'b1;
        idx_c   = ARB_ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// Round-robin arbiter sharing the ULPI controller register port between NUM_REQ
// requesters. Define ULPI_REG_ARB_TIMEOUT_EN to enable the GRANT watchdog.
module ulpi_reg_arbiter
  import usb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_en,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ*ULPI_REG_ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*ULPI_REG_DATA_W-1:0]   req_din,
  output logic [NUM_REQ-1:0]                   req_rdy,
  output logic [NUM_REQ-1:0]                   req_err,
  output logic [ULPI_REG_DATA_W-1:0]           req_dout,
  output logic [ARB_ID_W-1:0]                  grant_id,
  output logic                                 busy,
  output logic                                 reg_en,
  output logic                                 reg_we,
  output logic [ULPI_REG_ADDR_W-1:0]           reg_addr,
  output logic [ULPI_REG_DATA_W-1:0]           reg_din,
  input  logic                                 reg_rdy,
  input  logic [ULPI_REG_DATA_W-1:0]           reg_dout
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("ulpi_reg_arbiter: NUM_REQ must be within 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ulpi_reg_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e                 state_q, state_d;
  logic [ARB_ID_W-1:0]        last_q, last_d;
  logic [ARB_ID_W-1:0]        gid_q, gid_d;
  ulpi_reg_cmd_t              cmd_q, cmd_d;
  ulpi_reg_cmd_t              pick_cmd;
  logic                       en_q, en_d;
  logic                       busy_q, busy_d;
  logic [NUM_REQ-1:0]         rdy_q, rdy_d;
  logic [NUM_REQ-1:0]         grant_oh;
  logic [ULPI_REG_DATA_W-1:0] dout_q, dout_d;
  logic                       pick_valid;
  logic [ARB_ID_W-1:0]        pick_idx;

`ifdef ULPI_REG_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  assign req_err = err_q;
`else
  assign req_err = '0;
`endif

  usb_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i   (req_en),
    .last_i  (last_q),
    .valid_c (pick_valid),
    .idx_c   (pick_idx)
  );

  always_comb begin
    pick_cmd.we   = 1'(req_we >> pick_idx);
    pick_cmd.addr = ULPI_REG_ADDR_W'(req_addr >> (ULPI_REG_ADDR_W * 32'(pick_idx)));
    pick_cmd.din  = ULPI_REG_DATA_W'(req_din >> (ULPI_REG_DATA_W * 32'(pick_idx)));
  end

  assign grant_oh = NUM_REQ'(1) << gid_q;

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    cmd_d   = cmd_q;
    en_d    = en_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    rdy_d   = '0;
`ifdef ULPI_REG_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = '0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          cmd_d   = pick_cmd;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          gid_d   = pick_idx;
          last_d  = pick_idx;
          state_d = ARB_GRANT;
`ifdef ULPI_REG_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (reg_rdy) begin
          en_d    = 1'b0;
          dout_d  = cmd_q.we ? '0 : reg_dout;
          rdy_d   = grant_oh;
          state_d = ARB_DONE;
        end
`ifdef ULPI_REG_ARB_TIMEOUT_EN
        else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          en_d    = 1'b0;
          dout_d  = '0;
          rdy_d   = grant_oh;
          err_d   = grant_oh;
          state_d = ARB_DONE;
        end else begin
          cnt_d   = cnt_q + TO_W'(1);
        end
`endif
      end
      ARB_DONE: begin
        busy_d  = 1'b0;
        state_d = ARB_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      last_q  <= ARB_ID_W'(NUM_REQ - 1);
      gid_q   <= '0;
      cmd_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      rdy_q   <= '0;
`ifdef ULPI_REG_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      cmd_q   <= cmd_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
`ifdef ULPI_REG_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign req_rdy  = rdy_q;
  assign req_dout = dout_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;
  assign reg_en   = en_q;
  assign reg_we   = cmd_q.we;
  assign reg_addr = cmd_q.addr;
  assign reg_din  = cmd_q.din;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Self-checking bench for ulpi_reg_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_ulpi_reg_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned TO = 16;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_en, req_we, req_rdy, req_err;
  logic [NR*8-1:0] req_addr, req_din;
  logic [7:0]      req_dout, reg_addr, reg_din, reg_dout;
  logic [2:0]      grant_id;
  logic            busy, reg_en, reg_we, reg_rdy;

  ulpi_reg_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_en(req_en), .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
    .req_rdy(req_rdy), .req_err(req_err), .req_dout(req_dout),
    .grant_id(grant_id), .busy(busy),
    .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr), .reg_din(reg_din),
    .reg_rdy(reg_rdy), .reg_dout(reg_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] phy_mem [256];
  logic [7:0] ref_mem [256];
  int         phy_delay = 1;
  int         phy_cnt   = 0;
  bit         phy_mute  = 1'b0;

  logic       sh_we   [NR];
  logic [7:0] sh_addr [NR];
  logic [7:0] sh_din  [NR];

  typedef struct {
    int unsigned req;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  din;
    int          dly;
    logic [2:0]  gid;
    logic [7:0]  dout;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic en, input logic we,
                         input logic [7:0] addr, input logic [7:0] din);
    req_en[i]        = en;
    req_we[i]        = we;
    req_addr[8*i +: 8] = addr;
    req_din[8*i +: 8]  = din;
    sh_we[i]   = we;
    sh_addr[i] = addr;
    sh_din[i]  = din;
  endtask

  // ULPI controller model: replies phy_delay cycles after reg_en rises.
  task automatic phy_step();
    if (!rst || reg_rdy) begin
      reg_rdy = 1'b0;
      phy_cnt = 0;
    end else if (reg_en && !phy_mute) begin
      phy_cnt++;
      if (phy_cnt >= phy_delay) begin
        reg_rdy  = 1'b1;
        reg_dout = phy_mem[reg_addr];
        if (reg_we) phy_mem[reg_addr] = reg_din;
      end
    end else begin
      phy_cnt = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    phy_step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < int'(NR); i++) set_req(i, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic wait_rdy(input int limit, output int n);
    n = 0;
    while (req_rdy == '0 && n < limit) begin
      tick();
      n++;
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= int'(NR); k++) begin
      int j;
      j = (last + k) % int'(NR);
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    phy_delay = v.dly;
    set_req(int'(v.req), 1'b1, v.we, v.addr, v.din);
    tick();
    chk({nm, " reg_en latency"}, 32'(reg_en), 1);
    chk({nm, " grant_id"}, 32'(grant_id), 32'(v.gid));
    chk({nm, " reg_addr"}, 32'(reg_addr), 32'(v.addr));
    chk({nm, " reg_we"}, 32'(reg_we), 32'(v.we));
    chk({nm, " reg_din"}, 32'(reg_din), 32'(v.din));
    wait_rdy(64, n);
    chk({nm, " rdy cycles"}, 32'(n), 32'(v.dly));
    chk({nm, " req_rdy"}, 32'(req_rdy), 32'(1) << v.gid);
    chk({nm, " req_dout"}, 32'(req_dout), 32'(v.dout));
    chk({nm, " req_err"}, 32'(req_err), 0);
    chk({nm, " reg_en low in DONE"}, 32'(reg_en), 0);
    set_req(int'(v.req), 1'b0, v.we, v.addr, v.din);
    tick();
    chk({nm, " busy after DONE"}, 32'(busy), 0);
    chk({nm, " rdy cleared"}, 32'(req_rdy), 0);
    chk({nm, " grant_id held"}, 32'(grant_id), 32'(v.gid));
  endtask

  initial begin
    vec_t            vecs [7];
    int              n, g, low_run, pulses, rises, held_bad;
    int              order [4];
    logic            prev_en, prev_busy, rdy_in, exp_rise;
    logic [NR-1:0]   applied, exp_rdy;
    int              exp_last, w, out_idx;
    bit              out_valid;
    logic            out_we;
    logic [7:0]      out_addr, out_din, exp_dout, x;

    vecs[0] = '{0, 1'b0, 8'h0A, 8'h00, 4, 3'd0, 8'h5C};
    vecs[1] = '{2, 1'b1, 8'h10, 8'h41, 2, 3'd2, 8'h00};
    vecs[2] = '{1, 1'b0, 8'h10, 8'h00, 1, 3'd1, 8'h41};
    vecs[3] = '{0, 1'b0, 8'hFF, 8'h00, 3, 3'd0, 8'hA9};
    vecs[4] = '{2, 1'b0, 8'h00, 8'h00, 6, 3'd2, 8'h56};
    vecs[5] = '{1, 1'b1, 8'hFF, 8'h12, 1, 3'd1, 8'h00};
    vecs[6] = '{0, 1'b0, 8'hFF, 8'h00, 2, 3'd0, 8'h12};

    for (int a = 0; a < 256; a++) phy_mem[a] = 8'(a) ^ 8'h56;
    reg_rdy  = 1'b0;
    reg_dout = 8'h00;
    do_reset();
    chk("reset outputs", {8'(req_rdy), 8'(req_err), req_dout, 5'(grant_id), busy, reg_en, reg_we,
                          reg_addr, reg_din}, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reg_rdy while IDLE must be ignored.
    reg_rdy = 1'b1;
    @(negedge clk);
    reg_rdy = 1'b0;
    tick();
    chk("stray reg_rdy", {30'(req_rdy), busy, reg_en}, 0);

    // Contention from reset: alternate 0,1 with exactly two idle cycles between accesses.
    do_reset();
    phy_delay = 2;
    set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
    g = 0; low_run = 0; prev_en = 1'b0; n = 0;
    while (g < 4 && n < 200) begin
      tick();
      n++;
      if (reg_en && !prev_en) begin
        order[g] = int'(grant_id);
        if (g > 0) chk($sformatf("contention gap%0d", g), 32'(low_run), 2);
        g++;
        low_run = 0;
      end else if (!reg_en) begin
        low_run++;
      end
      prev_en = reg_en;
    end
    chk("contention grants seen", 32'(g), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("contention order%0d", i), 32'(order[i]), 32'(i % 2));
    set_req(0, 1'b0, 1'b0, 8'h01, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h02, 8'h00);
    n = 0;
    while ((busy || reg_en) && n < 50) begin tick(); n++; end
    tick();

    // Write whose fields change mid-GRANT.
    phy_delay = 5;
    set_req(0, 1'b1, 1'b1, 8'h20, 8'h41);
    tick();
    chk("midgrant reg_din", 32'(reg_din), 32'h41);
    set_req(0, 1'b1, 1'b0, 8'h33, 8'hFF);
    held_bad = 0;
    n = 0;
    while (req_rdy == '0 && n < 64) begin
      tick();
      n++;
      if (req_rdy == '0 && (reg_din !== 8'h41 || reg_addr !== 8'h20 || reg_we !== 1'b1)) held_bad++;
    end
    chk("midgrant fields held", 32'(held_bad), 0);
    chk("midgrant req_rdy", 32'(req_rdy), 1);
    chk("midgrant req_dout", 32'(req_dout), 0);
    set_req(0, 1'b0, 1'b0, 8'h33, 8'hFF);
    tick();

    // req_en dropped during GRANT.
    phy_delay = 3;
    set_req(1, 1'b1, 1'b0, 8'h0A, 8'h00);
    tick();
    chk("drop grant_id", 32'(grant_id), 1);
    set_req(1, 1'b0, 1'b0, 8'h0A, 8'h00);
    pulses = 0; rises = 0; prev_en = reg_en;
    repeat (12) begin
      tick();
      if (req_rdy != '0) begin
        pulses++;
        chk("drop req_rdy", 32'(req_rdy), 2);
        chk("drop req_dout", 32'(req_dout), 32'h5C);
      end
      if (reg_en && !prev_en) rises++;
      prev_en = reg_en;
    end
    chk("drop pulse count", 32'(pulses), 1);
    chk("drop no regrant", 32'(rises), 0);

    // Asynchronous reset in the middle of GRANT.
    phy_mute = 1'b1;
    set_req(0, 1'b1, 1'b1, 8'h7E, 8'h99);
    tick();
    chk("rst-mid reg_en", 32'(reg_en), 1);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h0A, 8'h00);
    #2 rst = 1'b0;
    #1;
    chk("rst-mid outputs", {8'(req_rdy), 8'(req_err), req_dout, 5'(grant_id), busy, reg_en, reg_we,
                            reg_addr, reg_din}, 0);
    phy_mute = 1'b0;
    tick();
    rst = 1'b1;
    phy_delay = 2;
    tick();
    chk("rst-mid regrant en", 32'(reg_en), 1);
    chk("rst-mid regrant id", 32'(grant_id), 1);
    wait_rdy(64, n);
    chk("rst-mid rdy", 32'(req_rdy), 2);
    set_req(1, 1'b0, 1'b0, 8'h0A, 8'h00);
    tick();

`ifdef ULPI_REG_ARB_TIMEOUT_EN
    phy_mute = 1'b1;
    set_req(2, 1'b1, 1'b0, 8'h05, 8'h00);
    tick();
    wait_rdy(64, n);
    chk("timeout cycles", 32'(n), TO);
    chk("timeout req_rdy", 32'(req_rdy), 4);
    chk("timeout req_err", 32'(req_err), 4);
    chk("timeout req_dout", 32'(req_dout), 0);
    chk("timeout reg_en", 32'(reg_en), 0);
    set_req(2, 1'b0, 1'b0, 8'h05, 8'h00);
    tick();
    phy_mute  = 1'b0;
    phy_delay = TO;
    set_req(2, 1'b1, 1'b0, 8'h05, 8'h00);
    tick();
    wait_rdy(64, n);
    chk("tie cycles", 32'(n), TO);
    chk("tie req_rdy", 32'(req_rdy), 4);
    chk("tie req_err", 32'(req_err), 0);
    chk("tie req_dout", 32'(req_dout), 32'h53);
    set_req(2, 1'b0, 1'b0, 8'h05, 8'h00);
    tick();
`else
    phy_mute = 1'b1;
    set_req(2, 1'b1, 1'b0, 8'h05, 8'h00);
    tick();
    n = 0;
    repeat (1000) begin
      tick();
      if (reg_en && req_rdy == '0 && req_err == '0) n++;
    end
    chk("no timeout reg_en held", 32'(n), 1000);
    phy_mute = 1'b0;
`endif

    // Randomized traffic against a transaction-level round-robin model.
    do_reset();
    for (int a = 0; a < 256; a++) begin
      x = 8'($urandom);
      phy_mem[a] = x;
      ref_mem[a] = x;
    end
    exp_last = int'(NR) - 1;
    out_valid = 1'b0; out_idx = 0; out_we = 1'b0; out_addr = '0; out_din = '0;
    prev_busy = 1'b0; prev_en = 1'b0;
    phy_delay = 1;
    repeat (3000) begin
      @(negedge clk);
      applied = req_en;
      rdy_in  = reg_rdy;
      exp_rdy = (rdy_in && out_valid) ? NR'(1) << out_idx : '0;
      chk("rnd req_rdy", 32'(req_rdy), 32'(exp_rdy));
      chk("rnd req_err", 32'(req_err), 0);
      if (exp_rdy != '0) begin
        exp_dout = out_we ? 8'h00 : ref_mem[out_addr];
        chk("rnd req_dout", 32'(req_dout), 32'(exp_dout));
        if (out_we) ref_mem[out_addr] = out_din;
        out_valid = 1'b0;
      end
      exp_rise = !prev_busy && (applied != '0);
      chk("rnd grant start", 32'(reg_en && !prev_en), 32'(exp_rise));
      if (exp_rise) begin
        w = rr_pick(applied, exp_last);
        chk("rnd grant_id", 32'(grant_id), 32'(w));
        chk("rnd reg_cmd", {23'(reg_we), reg_addr, reg_din}, {23'(sh_we[w]), sh_addr[w], sh_din[w]});
        exp_last  = w;
        out_valid = 1'b1;
        out_idx   = w;
        out_we    = sh_we[w];
        out_addr  = sh_addr[w];
        out_din   = sh_din[w];
      end
      prev_busy = busy;
      prev_en   = reg_en;
      phy_step();
      if (!reg_en) phy_delay = int'($urandom_range(1, 4));
      for (int i = 0; i < int'(NR); i++) begin
        if (req_rdy[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'b1, 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom));
          else
            set_req(i, 1'b0, sh_we[i], sh_addr[i], sh_din[i]);
        end else if (!req_en[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, 1'b1, 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ulpi_reg_arbiter.md
Name: ulpi_reg_arbiter

Overview:
- Shares the single ULPI register-access port of the ULPI controller (reg_en/reg_we/reg_addr/reg_din -> reg_rdy/reg_dout) between NUM_REQ requesters, e.g. the USB state controller, a debug VIO/JTAG bridge and a future PHY init sequencer.
- Round-robin arbitration, one access in flight, registered downstream signals, per-requester completion pulse.
- Sits between the requesters and the ULPI controller, in the ULPI clock domain.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles; used only with ULPI_REG_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  ULPI clock (ulpi_clk).
- rst  in  1  asynchronous, active-low reset.
- req_en  in  NUM_REQ  per-requester access request; hold until req_rdy.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*8  flattened addresses; requester i at [8i+7:8i].
- req_din  in  NUM_REQ*8  flattened write data.
- req_rdy  out  NUM_REQ  one-cycle completion pulse for requester i.
- req_err  out  NUM_REQ  one-cycle timeout flag, coincident with req_rdy.
- req_dout  out  8  read data of the last completed access; valid when any req_rdy is high.
- grant_id  out  3  index of the current or last granted requester.
- busy  out  1  high while an access is in flight (GRANT or DONE).
- reg_en  out  1  to ULPI controller; held until reg_rdy.
- reg_we  out  1  to ULPI controller.
- reg_addr  out  8  to ULPI controller.
- reg_din  out  8  to ULPI controller.
- reg_rdy  in  1  from ULPI controller; one-cycle completion.
- reg_dout  in  8  from ULPI controller; valid with reg_rdy.

Behaviour:
- Reset (rst=0, async): state IDLE, last_grant=NUM_REQ-1; all outputs 0 (req_rdy, req_err, req_dout, grant_id, busy, reg_en, reg_we, reg_addr, reg_din).
- States: IDLE, GRANT, DONE. All outputs are registered.
- IDLE:
  - If any req_en is set, pick the first set bit scanning from (last_grant+1) mod NUM_REQ upward, with wrap.
  - Latch that requester's we/addr/din into reg_we/reg_addr/reg_din. Set reg_en=1, busy=1, grant_id=idx, last_grant=idx. Go to GRANT.
  - Latency: req_en sampled high at edge k -> reg_en high from cycle k+1.
- GRANT:
  - reg_en, reg_we, reg_addr and reg_din are held stable.
  - On reg_rdy=1: reg_en<=0; req_dout<=reg_dout for a read, or 0 for a write; req_rdy[grant_id]<=1. Go to DONE.
  - Changes on req_* inputs during GRANT are ignored. A dropped req_en does not abort the access; the rdy pulse is still issued.
- DONE:
  - Lasts exactly one cycle: req_rdy/req_err pulse high, busy high, no arbitration.
  - Next state IDLE with busy=0 and the pulses cleared.
  - The completed requester drops or renews req_en at the DONE->IDLE edge, so no spurious re-grant occurs.
- Minimum spacing: 2 cycles with reg_en low between consecutive accesses (DONE, then IDLE).
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0.
- reg_rdy outside GRANT is ignored.
- Reset mid-access: immediate return to the reset state. The ULPI controller shares the same reset.
- grant_id holds its value after completion until the next grant.

Optional Feature:
- Macro: ULPI_REG_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GRANT and increments each GRANT cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 with reg_rdy low: reg_en<=0, req_dout<=0, req_rdy[grant_id]<=1, req_err[grant_id]<=1. Go to DONE.
  - reg_rdy arriving in that same cycle wins: normal completion, no error.
- Undefined: no counter; req_err is tied to 0 and GRANT waits indefinitely.

Decomposition:
- Shared package usb_pkg: ULPI_REG_ADDR_W=8, ULPI_REG_DATA_W=8, arbiter state encoding (IDLE=0, GRANT=1, DONE=2).
- One sub-module, usb_rr_picker: combinational round-robin picker. Inputs: request vector and last_grant. Outputs: valid flag and index.

Test Plan:
- Single read: req_en[0]=1, we=0, addr=0x0A -> reg_en high next cycle with addr 0x0A. Model replies reg_rdy with reg_dout=0x5C after 4 cycles -> req_rdy[0] pulses for 1 cycle with req_dout=0x5C, then busy=0.
- Contention: req_en=2'b11 from reset -> requester 0 is served first, then requester 1. The two accesses are separated by 2 cycles of reg_en low. Continuous requests alternate 0,1,0,1.
- Write with fields changing mid-GRANT: req_din 0x41->0xFF during GRANT -> reg_din stays 0x41; req_rdy pulses; req_dout=0.
- req_en dropped during GRANT -> access still completes; req_rdy pulses once; no re-grant.
- Reset asserted mid-GRANT -> all outputs go to 0 asynchronously. After release, a pending req_en[1] alone is granted with grant_id=1.
- With ULPI_REG_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, model never asserts reg_rdy -> after 16 GRANT cycles req_rdy and req_err pulse together for the granted requester, req_dout=0, reg_en=0. Without the macro, reg_en stays high for 1000 cycles.
